// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_gen_pkg
// Brief   : Shared widths, reset PC and redirect-source encoding for fetch PC gen.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef RegW
`define RegW 32
`endif
`ifndef LOONG_PC_START_ADDR
`define LOONG_PC_START_ADDR 32'h1c000000
`endif

package fetch_pc_gen_pkg;

   localparam int                   XLEN_DEF     = `RegW;
   localparam logic [XLEN_DEF-1:0]  RESET_PC_DEF = `LOONG_PC_START_ADDR;

   typedef enum logic [2:0] {
      SRC_EX   = 3'd0,
      SRC_BRU  = 3'd1,
      SRC_PEND = 3'd2,
      SRC_BP   = 3'd3,
      SRC_SEQ  = 3'd4
   } redirect_src_e;

   // Slot index width, kept at least one bit so single-slot builds stay legal.
   function automatic int slot_w(input int fetch_w);
      return (fetch_w > 1) ? $clog2(fetch_w) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_slot_mask.sv
`default_nettype none
// ============================================================================
// Module  : fetch_slot_mask
// Brief   : Start slot + predicted-taken slot -> per-slot valid mask.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_slot_mask
   import fetch_pc_gen_pkg::*;
#(
   parameter int FETCH_W = 2,
   parameter int SLOT_W  = slot_w(FETCH_W)
) (
   input  logic [SLOT_W-1:0]  i_start_slot,
   input  logic               i_bp_taken,
   input  logic [SLOT_W-1:0]  i_bp_slot,
   output logic [FETCH_W-1:0] o_mask,
   output logic               o_taken
);

   logic w_taken;

   // A taken slot ahead of the entry point cannot end this group.
   assign w_taken = i_bp_taken & (i_bp_slot >= i_start_slot);
   assign o_taken = w_taken;

   generate
      for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
         assign o_mask[gi] = (SLOT_W'(gi) >= i_start_slot) &
                             (!w_taken | (SLOT_W'(gi) <= i_bp_slot));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_gen
// Brief   : IF-stage fetch-group PC generator with prioritised redirects.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter int               FETCH_W  = 2,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
   localparam int              SLOT_W   = slot_w(FETCH_W)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ex_redirect_i,
   input  logic [XLEN-1:0]    ex_pc_i,
   input  logic               bru_flush_i,
   input  logic [XLEN-1:0]    bru_pc_i,
   input  logic               bp_taken_i,
   input  logic [SLOT_W-1:0]  bp_slot_i,
   input  logic [XLEN-1:0]    bp_target_i,
   input  logic               if_ready_i,
   output logic               if_valid_o,
   output logic [XLEN-1:0]    if_pc_o,
   output logic [FETCH_W-1:0] if_slot_mask_o,
   output logic [XLEN-1:0]    if_predict_pc_o,
   output logic               if_pred_taken_o
);

   localparam logic [XLEN-1:0] C_GROUP_BYTES = XLEN'(FETCH_W * 4);
   localparam logic [XLEN-1:0] C_OFF_MASK    = XLEN'(FETCH_W * 4 - 1);
   localparam logic [XLEN-1:0] C_WORD_MASK   = XLEN'(3);

   logic [XLEN-1:0]    r_pc;
   logic               r_valid;
   logic               r_pend_v;
   logic [XLEN-1:0]    r_pend_pc;

   logic               w_fire;
   logic [XLEN-1:0]    w_seq_pc;
   logic [SLOT_W-1:0]  w_start_slot;
   logic [FETCH_W-1:0] w_mask;
   logic               w_taken;
   logic [XLEN-1:0]    w_bp_tgt;
   redirect_src_e      w_src;
   logic               w_load;
   logic [XLEN-1:0]    w_next_pc;

   assign w_fire   = r_valid & if_ready_i;
   assign w_seq_pc = (r_pc & ~C_OFF_MASK) + C_GROUP_BYTES;
   assign w_bp_tgt = bp_target_i & ~C_WORD_MASK;

   generate
      if (FETCH_W > 1) begin : g_multi_slot
         assign w_start_slot = r_pc[SLOT_W+1:2];
      end else begin : g_single_slot
         assign w_start_slot = '0;
      end
   endgenerate

   fetch_slot_mask #(
      .FETCH_W (FETCH_W),
      .SLOT_W  (SLOT_W)
   ) u_slot_mask (
      .i_start_slot (w_start_slot),
      .i_bp_taken   (bp_taken_i),
      .i_bp_slot    (bp_slot_i),
      .o_mask       (w_mask),
      .o_taken      (w_taken)
   );

   always_comb begin
      w_src  = SRC_SEQ;
      w_load = 1'b0;
      if (ex_redirect_i) begin
         w_src  = SRC_EX;
         w_load = 1'b1;
      end else if (bru_flush_i) begin
         w_src  = SRC_BRU;
         w_load = 1'b1;
      end else if (w_fire) begin
         w_load = 1'b1;
         if (r_pend_v)
            w_src = SRC_PEND;
         else if (w_taken)
            w_src = SRC_BP;
      end
   end

   always_comb begin
      w_next_pc = w_seq_pc;
      case (w_src)
         SRC_EX:   w_next_pc = ex_pc_i & ~C_WORD_MASK;
         SRC_BRU:  w_next_pc = bru_pc_i & ~C_WORD_MASK;
         SRC_PEND: w_next_pc = r_pend_pc;
         SRC_BP:   w_next_pc = w_bp_tgt;
         default:  w_next_pc = w_seq_pc;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc      <= RESET_PC;
         r_valid   <= 1'b0;
         r_pend_v  <= 1'b0;
         r_pend_pc <= '0;
      end else begin
         r_valid <= 1'b1;
         if (w_load)
            r_pc <= w_next_pc;
         // The first prediction seen during a stall is the one that steers the group.
         if (ex_redirect_i | bru_flush_i | w_fire) begin
            r_pend_v <= 1'b0;
         end else if (r_valid & w_taken & !r_pend_v) begin
            r_pend_v  <= 1'b1;
            r_pend_pc <= w_bp_tgt;
         end
      end
   end

   assign if_valid_o      = r_valid;
   assign if_pc_o         = r_pc;
   assign if_predict_pc_o = r_pc;
   assign if_slot_mask_o  = r_valid ? w_mask : '0;
   assign if_pred_taken_o = r_valid & w_taken;

endmodule

`default_nettype wire
